ship_flood_bfs: RTL and testbench
=================================

// Module: ship_flood_bfs
// PURPOSE
//  Parametrised successor to the single-neighbour sink check. Runs a true BFS flood over the
//  4-connected component of hit cells around a newly hit (x,y) on a GRID_W x GRID_H board.
//  Declares the ship sunk only if no intact cell touches the component.
//  Sits between game control and the board memory; shares the 2-bit cell memory handshake.
//  Cell code: 00 water, 01 intact ship, 10 hit, 11 sunk.
// PARAMETERS
//  GRID_W  6   board columns (1..2**CW)
//  GRID_H  6   board rows (1..2**CW)
//  CW      3   coordinate width
//  QDEPTH  16  BFS FIFO entries (power of 2)
//  NW      6   cell-count width; must hold GRID_W*GRID_H
// PORTS
//  clk           in   1   clock; all logic on posedge
//  rstn          in   1   synchronous active-low reset
//  x, y          in   CW  seed coordinate, sampled on accepted start
//  bfs_start     in   1   level request; accepted only in IDLE
//  mem_addr_x/y  out  CW  cell address
//  mem_wr_en     out  1   1 = write, 0 = read (valid with mem_in_valid)
//  mem_wr_data   out  2   write data
//  mem_in_valid  out  1   one-cycle request strobe
//  mem_rd_data   in   2   read data, valid when mem_ready=1
//  mem_ready     in   1   request complete
//  bfs_done      out  1   result valid; held until bfs_start=0
//  bfs_sink      out  1   component fully hit
//  bfs_err       out  1   FIFO overflow abort
//  bfs_count     out  NW  hit cells found in component
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state IDLE; all outputs 0; FIFO empty; visited map cleared.
//   Applies mid-search. Any outstanding memory reply after reset is ignored.
//  Memory handshake:
//   - One outstanding request only. mem_in_valid is high for exactly 1 cycle; addr/wr fields
//     are held until mem_ready.
//   - mem_ready is sampled from the cycle after the strobe onward; rd_data is taken in the
//     mem_ready cycle. A zero-wait memory gives 2 cycles per access.
//  FSM states:
//   - IDLE: on bfs_start, latch x,y; clear visited map, count and flags; go SEED.
//   - SEED: read the seed cell.
//     - Reply != 10 -> DONE with sink=0, count=0.
//     - Reply = 10 -> push seed, mark visited, count=1, go POP.
//   - POP: FIFO empty -> DONE with sink=1. Otherwise pop the current cell; neighbour index=0.
//   - NB: neighbours are checked in order L(x-1), R(x+1), U(y+1), D(y-1).
//     - Off-grid or already visited: skip in 1 cycle with no request issued.
//     - Otherwise read the cell:
//       - 01 -> DONE with sink=0 (early exit).
//       - 10 -> push, mark visited, count++.
//       - 00/11 -> ignore.
//     - After D, go POP.
//   - Push while FIFO full -> DONE with err=1, sink=0.
//   - DONE: assert bfs_done with sink/err/count stable. On bfs_start=0 drop done, sink and err
//     (count is held) and go IDLE.
//  Other rules:
//   - Visited map is GRID_W*GRID_H bits, indexed y*GRID_W+x. Each cell is pushed at most once.
//   - Coordinates compare unsigned. x=0 has no L; x=GRID_W-1 has no R. Same for y.
//   - Seed outside the grid -> DONE with sink=0, count=0, no memory access.
//   - Simultaneous push and pop cannot occur; FIFO pointers wrap modulo QDEPTH.
// CONFIGURATION
//  SHIP_FLOOD_MARK_EN defined:
//   - On a sink=1 result, before DONE, scan the visited map in index order and write 11 to
//     every visited cell (one write per cell, each waiting for mem_ready).
//   - bfs_done rises only after the final write completes.
//  SHIP_FLOOD_MARK_EN undefined:
//   - No writes are ever issued (mem_wr_en is tied 0).
//   - The sink result goes directly to DONE.
// TESTING
//  1. Isolated hit at (2,2), all neighbours 00 -> 4 reads after seed; done, sink=1, count=1.
//  2. Row (1,2),(2,2),(3,2) all 10, seed (2,2) -> sink=1, count=3, no repeat reads of a cell.
//  3. Same row with (3,2)=01 -> sink=0 on reading (3,2); no further requests.
//  4. Seed (0,0)=10 alone -> no request ever addresses x or y outside 0..5; sink=1.
//  5. QDEPTH=2, plus shape of 5 hits -> err=1, sink=0. Reset mid-search -> all outputs 0 next cycle.
//  6. MARK_EN with case 2 -> 3 writes of 11 to (1,2),(2,2),(3,2), then done. mem_ready delayed 3
//     cycles -> same result.

Source files
------------

// File: rtl/ship_flood_bfs.sv
// BFS flood over the 4-connected hit component around a seed cell; reports sunk when no intact cell borders it.
// Optional SHIP_FLOOD_MARK_EN: on a sink result, rewrite every visited cell as 11 before reporting done.
module ship_flood_bfs #(
    parameter int GRID_W = 6,
    parameter int GRID_H = 6,
    parameter int CW     = 3,
    parameter int QDEPTH = 16,
    parameter int NW     = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          bfs_start,
    output logic [CW-1:0] mem_addr_x,
    output logic [CW-1:0] mem_addr_y,
    output logic          mem_wr_en,
    output logic [1:0]    mem_wr_data,
    output logic          mem_in_valid,
    input  logic [1:0]    mem_rd_data,
    input  logic          mem_ready,
    output logic          bfs_done,
    output logic          bfs_sink,
    output logic          bfs_err,
    output logic [NW-1:0] bfs_count
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int QW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int PW    = IW + CW + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SEED, S_SEED_W, S_POP, S_NB, S_NB_W, S_MARK, S_MARK_W, S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cx, cy;
    logic [1:0]         nb;
    logic [NCELL-1:0]   visited;
    logic [CW-1:0]      fifo_x [QDEPTH];
    logic [CW-1:0]      fifo_y [QDEPTH];
    logic [QW-1:0]      rd_ptr, wr_ptr;
    logic [QW:0]        fcnt;

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] cxx, input logic [CW-1:0] cyy);
        logic [PW-1:0] p;
        p = PW'(cyy) * PW'(GRID_W) + PW'(cxx);
        return p[IW-1:0];
    endfunction

    logic [CW-1:0] nb_x, nb_y;
    logic          nb_ok, nb_seen, seed_in, fifo_full;
    logic [IW-1:0] nb_idx, seed_idx;

    // Boundary tests are done one bit wider so GRID_W == 2**CW still compares correctly.
    always_comb begin
        nb_x  = cx;
        nb_y  = cy;
        nb_ok = 1'b0;
        case (nb)
            2'd0: begin nb_x = cx - 1'b1; nb_ok = (cx != '0); end
            2'd1: begin nb_x = cx + 1'b1; nb_ok = ({1'b0, cx} < (CW+1)'(GRID_W - 1)); end
            2'd2: begin nb_y = cy + 1'b1; nb_ok = ({1'b0, cy} < (CW+1)'(GRID_H - 1)); end
            default: begin nb_y = cy - 1'b1; nb_ok = (cy != '0); end
        endcase
    end

    assign nb_idx    = cell_idx(nb_x, nb_y);
    assign nb_seen   = nb_ok ? visited[nb_idx] : 1'b1;
    assign seed_idx  = cell_idx(cx, cy);
    assign seed_in   = ({1'b0, cx} < (CW+1)'(GRID_W)) && ({1'b0, cy} < (CW+1)'(GRID_H));
    assign fifo_full = (fcnt == (QW+1)'(QDEPTH));

`ifdef SHIP_FLOOD_MARK_EN
    logic [CW-1:0] mark_x, mark_y;
    logic          mark_last, wr_en_r;
    logic [1:0]    wr_data_r;
    assign mark_last   = (mark_x == CW'(GRID_W - 1)) && (mark_y == CW'(GRID_H - 1));
    assign mem_wr_en   = wr_en_r;
    assign mem_wr_data = wr_data_r;
`else
    assign mem_wr_en   = 1'b0;
    assign mem_wr_data = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cx           <= '0;
            cy           <= '0;
            nb           <= '0;
            visited      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fcnt         <= '0;
            mem_addr_x   <= '0;
            mem_addr_y   <= '0;
            mem_in_valid <= 1'b0;
            bfs_done     <= 1'b0;
            bfs_sink     <= 1'b0;
            bfs_err      <= 1'b0;
            bfs_count    <= '0;
`ifdef SHIP_FLOOD_MARK_EN
            mark_x       <= '0;
            mark_y       <= '0;
            wr_en_r      <= 1'b0;
            wr_data_r    <= 2'b00;
`endif
        end else begin
            mem_in_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bfs_start) begin
                        cx        <= x;
                        cy        <= y;
                        visited   <= '0;
                        bfs_count <= '0;
                        bfs_sink  <= 1'b0;
                        bfs_err   <= 1'b0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        fcnt      <= '0;
                        state     <= S_SEED;
                    end
                end
                S_SEED: begin
                    if (seed_in) begin
                        mem_addr_x   <= cx;
                        mem_addr_y   <= cy;
                        mem_in_valid <= 1'b1;
`ifdef SHIP_FLOOD_MARK_EN
                        wr_en_r      <= 1'b0;
`endif
                        state        <= S_SEED_W;
                    end else begin
                        bfs_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                // mem_in_valid still high means this is the strobe cycle; the reply comes later.
                S_SEED_W: begin
                    if (!mem_in_valid && mem_ready) begin
                        if (mem_rd_data == 2'b10) begin
                            fifo_x[wr_ptr]     <= cx;
                            fifo_y[wr_ptr]     <= cy;
                            wr_ptr             <= wr_ptr + 1'b1;
                            fcnt               <= fcnt + 1'b1;
                            visited[seed_idx]  <= 1'b1;
                            bfs_count          <= NW'(1);
                            state              <= S_POP;
                        end else begin
                            bfs_done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_POP: begin
                    if (fcnt == '0) begin
`ifdef SHIP_FLOOD_MARK_EN
                        mark_x <= '0;
                        mark_y <= '0;
                        state  <= S_MARK;
`else
                        bfs_sink <= 1'b1;
                        bfs_done <= 1'b1;
                        state    <= S_DONE;
`endif
                    end else begin
                        cx     <= fifo_x[rd_ptr];
                        cy     <= fifo_y[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                        fcnt   <= fcnt - 1'b1;
                        nb     <= '0;
                        state  <= S_NB;
                    end
                end
                S_NB: begin
                    if (nb_seen) begin
                        nb    <= nb + 2'd1;
                        state <= (nb == 2'd3) ? S_POP : S_NB;
                    end else begin
                        mem_addr_x   <= nb_x;
                        mem_addr_y   <= nb_y;
                        mem_in_valid <= 1'b1;
`ifdef SHIP_FLOOD_MARK_EN
                        wr_en_r      <= 1'b0;
`endif
                        state        <= S_NB_W;
                    end
                end
                S_NB_W: begin
                    if (!mem_in_valid && mem_ready) begin
                        if (mem_rd_data == 2'b01) begin
                            bfs_done <= 1'b1;
                            state    <= S_DONE;
                        end else if (mem_rd_data == 2'b10 && fifo_full) begin
                            bfs_err  <= 1'b1;
                            bfs_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            if (mem_rd_data == 2'b10) begin
                                fifo_x[wr_ptr]  <= nb_x;
                                fifo_y[wr_ptr]  <= nb_y;
                                wr_ptr          <= wr_ptr + 1'b1;
                                fcnt            <= fcnt + 1'b1;
                                visited[nb_idx] <= 1'b1;
                                bfs_count       <= bfs_count + NW'(1);
                            end
                            nb    <= nb + 2'd1;
                            state <= (nb == 2'd3) ? S_POP : S_NB;
                        end
                    end
                end
`ifdef SHIP_FLOOD_MARK_EN
                S_MARK: begin
                    if (visited[cell_idx(mark_x, mark_y)]) begin
                        mem_addr_x   <= mark_x;
                        mem_addr_y   <= mark_y;
                        mem_in_valid <= 1'b1;
                        wr_en_r      <= 1'b1;
                        wr_data_r    <= 2'b11;
                        state        <= S_MARK_W;
                    end else if (mark_last) begin
                        bfs_sink <= 1'b1;
                        bfs_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        mark_x <= (mark_x == CW'(GRID_W - 1)) ? '0 : mark_x + 1'b1;
                        mark_y <= (mark_x == CW'(GRID_W - 1)) ? mark_y + 1'b1 : mark_y;
                    end
                end
                S_MARK_W: begin
                    if (!mem_in_valid && mem_ready) begin
                        if (mark_last) begin
                            bfs_sink <= 1'b1;
                            bfs_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            mark_x <= (mark_x == CW'(GRID_W - 1)) ? '0 : mark_x + 1'b1;
                            mark_y <= (mark_x == CW'(GRID_W - 1)) ? mark_y + 1'b1 : mark_y;
                            state  <= S_MARK;
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (!bfs_start) begin
                        bfs_done <= 1'b0;
                        bfs_sink <= 1'b0;
                        bfs_err  <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ship_flood_bfs.sv
// Bench for ship_flood_bfs: two instances (FIFO depth 16 and 2) sharing a board memory model,
// directed vector table, overflow and reset sequences, and random boards against a BFS reference.
module tb_ship_flood_bfs;
    localparam int W = 6;
    localparam int H = 6;
    localparam int CW = 3;
    localparam int NW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [CW-1:0] x, y;
    logic          start [2];
    logic [CW-1:0] ax [2];
    logic [CW-1:0] ay [2];
    logic          wen [2];
    logic [1:0]    wdata [2];
    logic          vld [2];
    logic [1:0]    rdata [2];
    logic          rdy [2];
    logic          done [2];
    logic          sink [2];
    logic          err [2];
    logic [NW-1:0] cnt [2];

    ship_flood_bfs #(.GRID_W(W), .GRID_H(H), .CW(CW), .QDEPTH(16), .NW(NW)) u_dut (
        .clk(clk), .rstn(rstn), .x(x), .y(y), .bfs_start(start[0]),
        .mem_addr_x(ax[0]), .mem_addr_y(ay[0]), .mem_wr_en(wen[0]), .mem_wr_data(wdata[0]),
        .mem_in_valid(vld[0]), .mem_rd_data(rdata[0]), .mem_ready(rdy[0]),
        .bfs_done(done[0]), .bfs_sink(sink[0]), .bfs_err(err[0]), .bfs_count(cnt[0])
    );

    ship_flood_bfs #(.GRID_W(W), .GRID_H(H), .CW(CW), .QDEPTH(2), .NW(NW)) u_small (
        .clk(clk), .rstn(rstn), .x(x), .y(y), .bfs_start(start[1]),
        .mem_addr_x(ax[1]), .mem_addr_y(ay[1]), .mem_wr_en(wen[1]), .mem_wr_data(wdata[1]),
        .mem_in_valid(vld[1]), .mem_rd_data(rdata[1]), .mem_ready(rdy[1]),
        .bfs_done(done[1]), .bfs_sink(sink[1]), .bfs_err(err[1]), .bfs_count(cnt[1])
    );

    logic [1:0] board [W*H];
    int ready_delay = 0;
    int pend [2] = '{0, 0};
    int dcnt [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};
    int wr_cnt [2] = '{0, 0};
    int bad_cnt [2] = '{0, 0};
    int last_wr [2] = '{-1, -1};
    int checks = 0;
    int errors = 0;

    // Memory model: ready comes ready_delay cycles after the cycle following the strobe.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int a;
            rdy[k] = 1'b0;
            if (!rstn) begin
                pend[k] = 0;
            end else if (vld[k]) begin
                a = 0;
                if (int'(ax[k]) >= W || int'(ay[k]) >= H) bad_cnt[k]++;
                else a = int'(ay[k]) * W + int'(ax[k]);
                if (wen[k]) begin
                    wr_cnt[k]++;
                    if (wdata[k] != 2'b11 || board[a] != 2'b10 || a <= last_wr[k]) bad_cnt[k]++;
                    board[a] = wdata[k];
                    last_wr[k] = a;
                end else begin
                    rd_cnt[k]++;
                    rdata[k] = board[a];
                end
                pend[k] = 1;
                dcnt[k] = ready_delay;
            end else if (pend[k] != 0) begin
                if (dcnt[k] == 0) begin
                    rdy[k] = 1'b1;
                    pend[k] = 0;
                end else begin
                    dcnt[k]--;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] c(input int xx, input int yy);
        logic [35:0] one;
        one = 36'd1;
        return one << (yy * W + xx);
    endfunction

    task automatic load_board(input logic [35:0] hits, input logic [35:0] intact);
        for (int i = 0; i < W * H; i++)
            board[i] = hits[i] ? 2'b10 : (intact[i] ? 2'b01 : 2'b00);
    endtask

    // Reference BFS straight from the game rules: L,R,U,D order, visited set on push, early exit on intact.
    task automatic model(input int sx, input int sy, input int qd,
                         output int m_sink, output int m_cnt, output int m_err, output int m_reads);
        int q[$];
        logic [35:0] vis;
        int cur, nx, ny, n;
        m_sink = 0; m_cnt = 0; m_err = 0; m_reads = 0;
        if (sx >= W || sy >= H) return;
        m_reads = 1;
        if (board[sy * W + sx] != 2'b10) return;
        vis = '0;
        vis[sy * W + sx] = 1'b1;
        q.push_back(sy * W + sx);
        m_cnt = 1;
        while (q.size() > 0) begin
            cur = q.pop_front();
            for (int d = 0; d < 4; d++) begin
                nx = cur % W;
                ny = cur / W;
                case (d)
                    0: nx = nx - 1;
                    1: nx = nx + 1;
                    2: ny = ny + 1;
                    default: ny = ny - 1;
                endcase
                if (nx < 0 || nx >= W || ny < 0 || ny >= H) continue;
                n = ny * W + nx;
                if (vis[n]) continue;
                m_reads++;
                if (board[n] == 2'b01) return;
                if (board[n] == 2'b10) begin
                    if (q.size() >= qd) begin
                        m_err = 1;
                        return;
                    end
                    q.push_back(n);
                    vis[n] = 1'b1;
                    m_cnt++;
                end
            end
        end
        m_sink = 1;
    endtask

    task automatic run_case(input string tag, input int k, input int sx, input int sy,
                            input int e_sink, input int e_cnt, input int e_err, input int e_reads);
        int n, e_wr;
`ifdef SHIP_FLOOD_MARK_EN
        e_wr = (e_sink != 0) ? e_cnt : 0;
`else
        e_wr = 0;
`endif
        @(negedge clk); #1;
        rd_cnt[k] = 0; wr_cnt[k] = 0; bad_cnt[k] = 0; last_wr[k] = -1;
        x = CW'(sx);
        y = CW'(sy);
        start[k] = 1'b1;
        n = 0;
        while (!done[k] && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".done_in_time"}, int'(done[k]), 1);
        chk({tag, ".sink"}, int'(sink[k]), e_sink);
        chk({tag, ".count"}, int'(cnt[k]), e_cnt);
        chk({tag, ".err"}, int'(err[k]), e_err);
        chk({tag, ".reads"}, rd_cnt[k], e_reads);
        chk({tag, ".writes"}, wr_cnt[k], e_wr);
        chk({tag, ".bad_access"}, bad_cnt[k], 0);
        @(negedge clk); #1;
        start[k] = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, int'({done[k], sink[k], err[k]}), 0);
        chk({tag, ".count_held"}, int'(cnt[k]), e_cnt);
    endtask

    typedef struct {
        int sx, sy;
        logic [35:0] hits, intact;
        int e_sink, e_cnt, e_reads;
    } vec_t;

    vec_t vt [10];

    initial begin
        int ms, mc, me, mr, k, sx, sy, r;
        logic [35:0] row;

        row = c(1, 2) | c(2, 2) | c(3, 2);
        vt[0] = '{2, 2, c(2, 2), '0, 1, 1, 5};
        vt[1] = '{2, 2, row, '0, 1, 3, 11};
        vt[2] = '{2, 2, c(1, 2) | c(2, 2), c(3, 2), 0, 2, 3};
        vt[3] = '{0, 0, c(0, 0), '0, 1, 1, 3};
        vt[4] = '{2, 2, '0, '0, 0, 0, 1};
        vt[5] = '{6, 2, '1, '0, 0, 0, 0};
        vt[6] = '{7, 7, '1, '0, 0, 0, 0};
        vt[7] = '{5, 5, c(5, 5) | c(4, 5), '0, 1, 2, 5};
        vt[8] = '{3, 3, '0, c(3, 3), 0, 0, 1};
        vt[9] = '{2, 2, row | c(2, 3) | c(2, 1), '0, 1, 5, 17};

        rstn = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        x = '0;
        y = '0;
        for (int i = 0; i < W * H; i++) board[i] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("reset%0d.outputs", j),
                int'({vld[j], wen[j], done[j], sink[j], err[j]}), 0);
            chk($sformatf("reset%0d.count", j), int'(cnt[j]), 0);
        end
        @(negedge clk); #1;
        rstn = 1'b1;

        for (int d = 0; d < 4; d += 3) begin
            ready_delay = d;
            for (int i = 0; i < 10; i++) begin
                load_board(vt[i].hits, vt[i].intact);
                run_case($sformatf("vec%0d_d%0d", i, d), 0, vt[i].sx, vt[i].sy,
                         vt[i].e_sink, vt[i].e_cnt, 0, vt[i].e_reads);
            end
        end

        ready_delay = 1;
        load_board(row | c(2, 3) | c(2, 1), '0);
        run_case("overflow_q2", 1, 2, 2, 0, 3, 1, 4);

        ready_delay = 2;
        load_board('1, '0);
        @(negedge clk); #1;
        start[0] = 1'b1;
        x = 3'd2;
        y = 3'd2;
        repeat (30) @(negedge clk);
        #1;
        rstn = 1'b0;
        start[0] = 1'b0;
        @(posedge clk); #1;
        chk("midreset.strobe", int'({vld[0], wen[0]}), 0);
        chk("midreset.flags", int'({done[0], sink[0], err[0]}), 0);
        chk("midreset.count", int'(cnt[0]), 0);
        chk("midreset.addr", int'({ax[0], ay[0]}), 0);
        @(negedge clk); #1;
        rstn = 1'b1;
        load_board(row, '0);
        run_case("after_reset", 0, 2, 2, 1, 3, 0, 11);

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < W * H; j++) begin
                r = $urandom_range(0, 19);
                board[j] = (r < 11) ? 2'b10 : (r < 16) ? 2'b00 : (r < 17) ? 2'b01 : 2'b11;
            end
            k = $urandom_range(0, 3) == 0 ? 1 : 0;
            sx = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            sy = $urandom_range(0, 5);
            ready_delay = $urandom_range(0, 2);
            model(sx, sy, (k == 1) ? 2 : 16, ms, mc, me, mr);
            run_case($sformatf("rand%0d", i), k, sx, sy, ms, mc, me, mr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
